// File: rtl/hello_world.sv
// 4-bit ripple-carry adder (A+B+CIN) with registered sum/carry; HELLO_WORLD_INREG_EN adds an input flop stage.
// Latency 1 cycle (2 with HELLO_WORLD_INREG_EN); one result per cycle.
// No backpressure: a new operand set is accepted every cycle.
module hello_world (
  input  logic clk,
  input  logic rst_n,
  input  logic a0_pad_pad,
  input  logic a1_pad_pad,
  input  logic a2_pad_pad,
  input  logic a3_pad_pad,
  input  logic b0_pad_pad,
  input  logic b1_pad_pad,
  input  logic b2_pad_pad,
  input  logic b3_pad_pad,
  input  logic cin_pad_pad,
  output logic s0_final_output_outbuf_out,
  output logic s1_final_output_outbuf_out,
  output logic s2_final_output_outbuf_out,
  output logic s3_final_output_outbuf_out,
  output logic cout_final_output_outbuf_out
);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
  } opnd_t;

  opnd_t      pad_opnd;
  opnd_t      add_opnd;
  logic [4:0] carry;
  logic [3:0] sum;
  logic [4:0] res_q;

  assign pad_opnd.a   = {a3_pad_pad, a2_pad_pad, a1_pad_pad, a0_pad_pad};
  assign pad_opnd.b   = {b3_pad_pad, b2_pad_pad, b1_pad_pad, b0_pad_pad};
  assign pad_opnd.cin = cin_pad_pad;

`ifdef HELLO_WORLD_INREG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_opnd <= '0;
    end else begin
      add_opnd <= pad_opnd;
    end
  end
`else
  assign add_opnd = pad_opnd;
`endif

  // Explicit ripple chain so each bit maps to one full-adder cell.
  assign carry[0] = add_opnd.cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    logic p;
    assign p          = add_opnd.a[i] ^ add_opnd.b[i];
    assign sum[i]     = p ^ carry[i];
    assign carry[i+1] = (add_opnd.a[i] & add_opnd.b[i]) | (carry[i] & p);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= {carry[4], sum};
    end
  end

  assign s0_final_output_outbuf_out   = res_q[0];
  assign s1_final_output_outbuf_out   = res_q[1];
  assign s2_final_output_outbuf_out   = res_q[2];
  assign s3_final_output_outbuf_out   = res_q[3];
  assign cout_final_output_outbuf_out = res_q[4];

endmodule

// File: tb/tb_hello_world.sv
// Scoreboard bench for hello_world: stimulus queues expected {cout,s} with a due cycle, monitor pops on negedge.
module tb_hello_world;

`ifdef HELLO_WORLD_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int         due;
    logic [4:0] val;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] a, b;
  logic cin;
  logic s0, s1, s2, s3, cout;
  logic [4:0] res;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  assign res = {cout, s3, s2, s1, s0};

  hello_world dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .a0_pad_pad                   (a[0]),
    .a1_pad_pad                   (a[1]),
    .a2_pad_pad                   (a[2]),
    .a3_pad_pad                   (a[3]),
    .b0_pad_pad                   (b[0]),
    .b1_pad_pad                   (b[1]),
    .b2_pad_pad                   (b[2]),
    .b3_pad_pad                   (b[3]),
    .cin_pad_pad                  (cin),
    .s0_final_output_outbuf_out   (s0),
    .s1_final_output_outbuf_out   (s1),
    .s2_final_output_outbuf_out   (s2),
    .s3_final_output_outbuf_out   (s3),
    .cout_final_output_outbuf_out (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_now(input string name, input logic [4:0] req);
    checks++;
    if (res !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b at t=%0t", name, res, req, $time);
    end
  endtask

  // Monitor: compares every result whose due cycle has arrived; in reset the outputs must read 0.
  always @(negedge clk) begin
    if (rst_n === 1'b0) begin
      check_now("reset_zero", 5'd0);
    end
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.due != cyc || res !== e.val) begin
        errors++;
        $display("FAIL %s: got %b (cycle %0d) required %b (cycle %0d)", e.name, res, cyc, e.val, e.due);
      end
    end
  end

  task automatic push_exp(input int due, input logic [4:0] val, input string name);
    exp_t e;
    e.due = due; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic apply(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                       input logic [4:0] req, input string name);
    @(posedge clk); #1;
    a = ta; b = tb; cin = tc;
    push_exp(cyc + LAT, req, name);
  endtask

  initial begin
    rst_n = 1'b0; a = 4'd0; b = 4'd0; cin = 1'b0;
    #1;
    check_now("reset_no_clock", 5'd0);
    a = 4'd15; b = 4'd15; cin = 1'b1;
    #1;
    check_now("reset_inputs_max", 5'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check_now("reset_held", 5'd0);
    end
    a = 4'd0; b = 4'd0; cin = 1'b0;
    #2 rst_n = 1'b1;
    #1 check_now("release_before_edge", 5'd0);

    apply(4'd3,  4'd5,  1'b0, 5'b0_1000, "basic_3p5");
    apply(4'd15, 4'd0,  1'b1, 5'b1_0000, "ripple_15p0p1");
    apply(4'd15, 4'd15, 1'b1, 5'b1_1111, "ripple_15p15p1");
    apply(4'd1,  4'd1,  1'b0, 5'b0_0010, "stream_1p1");
    apply(4'd7,  4'd8,  1'b0, 5'b0_1111, "stream_7p8");
    apply(4'd9,  4'd9,  1'b1, 5'b1_0011, "stream_9p9p1");
    apply(4'd0,  4'd0,  1'b0, 5'b0_0000, "zero");
    repeat (LAT + 1) @(posedge clk);

    // Mid-stream reset: in-flight results are dropped.
    apply(4'd2, 4'd3, 1'b0, 5'd5, "flushed_a");
    apply(4'd4, 4'd4, 1'b0, 5'd8, "flushed_b");
    #1 rst_n = 1'b0;
    sb.delete();
    #1 check_now("midstream_async_clear", 5'd0);
    a = 4'd9; b = 4'd9; cin = 1'b1;
    #4 rst_n = 1'b1;
`ifdef HELLO_WORLD_INREG_EN
    push_exp(cyc + 1, 5'd0, "post_reset_inreg_cleared");
`endif
    push_exp(cyc + LAT, 5'b1_0011, "post_reset_first");
    apply(4'd6, 4'd5, 1'b1, 5'b0_1100, "post_reset_second");

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      apply(v[3:0], v[7:4], v[8], 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]), "exhaustive");
    end

    repeat (LAT + 3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never seen, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
